// File: rtl/udl_count_pkg.sv
// Shared definitions for the counter-bank scheduler.
//   OP_*      : requester opcodes (INC, DEC, LOAD, CLR)
//   NCNT      : number of counters in the shared bank
//   op_decode : opcode -> {rst, load, up, down} bank command vector
package udl_count_pkg;

    localparam logic [1:0] OP_INC  = 2'd0;
    localparam logic [1:0] OP_DEC  = 2'd1;
    localparam logic [1:0] OP_LOAD = 2'd2;
    localparam logic [1:0] OP_CLR  = 2'd3;

    localparam int NCNT = 4;

    // Exactly one bit is set for every opcode.
    function automatic logic [3:0] op_decode(input logic [1:0] op);
        op_decode = 4'b0000;
        case (op)
            OP_INC:  op_decode = 4'b0010;
            OP_DEC:  op_decode = 4'b0001;
            OP_LOAD: op_decode = 4'b0100;
            OP_CLR:  op_decode = 4'b1000;
            default: op_decode = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/udl_count_sched_rr_arb.sv
// Combinational round-robin arbiter.
//   cand  : candidate request vector
//   ptr   : highest-priority position this cycle
//   win   : one-hot winner (first set bit of cand scanning ptr, ptr+1, ...)
//   valid : a winner exists
module rr_arb #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] cand,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            valid
);

    logic [PW:0] pos;

    always_comb begin
        win   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Wrap ptr+k back into 0..NREQ-1 (NREQ need not be a power of two).
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(NREQ)) begin
                pos = pos - (PW+1)'(NREQ);
            end
            if (!valid && cand[pos[PW-1:0]]) begin
                win[pos[PW-1:0]] = 1'b1;
                valid            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udl_count_sched.sv
// Round-robin scheduler sharing one 4-entry up/down/load counter bank.
//   clk, rst_n        : clock, asynchronous active-low reset
//   en                : arbitration enable (in-flight command still completes)
//   req/op/idx/data   : per-requester command, held until gnt
//   gnt               : one-hot issue pulse (registered)
//   done, result      : one-hot completion pulse and post-update counter value
//   busy              : issue register holds a command
//   cb_*              : registered bank command/select/data lines
//   r3..r0            : bank counter outputs
module udl_count_sched
    import udl_count_pkg::*;
#(
    parameter int N    = 4,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op,
    input  logic [2*NREQ-1:0]    idx,
    input  logic [N*NREQ-1:0]    data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [N-1:0]         result,
    output logic                 busy,
    output logic                 cb_up,
    output logic                 cb_down,
    output logic                 cb_load,
    output logic                 cb_rst,
    output logic [1:0]           cb_rs,
    output logic [1:0]           cb_rd,
    output logic [N-1:0]         cb_in,
    input  logic [N-1:0]         r3,
    input  logic [N-1:0]         r2,
    input  logic [N-1:0]         r1,
    input  logic [N-1:0]         r0
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] cand, win;
    logic            win_vld;
    logic [PW-1:0]   w_idx;
    logic [1:0]      w_op, w_tgt;
    logic [N-1:0]    w_data;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic [3:0]      cmd_q, cmd_d;       // {rst, load, up, down}
    logic [1:0]      sel_q, sel_d;
    logic [N-1:0]    in_q, in_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [1:0]      done_sel_q, done_sel_d;

    logic [N-1:0]    r_vec [NCNT];

    // A requester whose gnt is high still has req high this cycle; mask it.
    assign cand = req & ~gnt_q & {NREQ{en}};

    rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
        .cand  (cand),
        .ptr   (ptr_q),
        .win   (win),
        .valid (win_vld)
    );

    always_comb begin
        w_idx  = '0;
        w_op   = OP_INC;
        w_tgt  = 2'd0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                w_idx  = PW'(i);
                w_op   = op[2*i +: 2];
                w_tgt  = idx[2*i +: 2];
                w_data = data[N*i +: N];
            end
        end

        ptr_d = ptr_q;
        if (win_vld) begin
            ptr_d = (w_idx == PW'(NREQ-1)) ? '0 : w_idx + PW'(1);
        end

        gnt_d  = win_vld ? win : '0;
        busy_d = win_vld;
        cmd_d  = win_vld ? op_decode(w_op) : 4'b0000;
        sel_d  = win_vld ? w_tgt : 2'd0;
        in_d   = (win_vld && w_op == OP_LOAD) ? w_data : '0;

        // The bank captures the issued command at the next edge, so the
        // completion stage simply trails the issue stage by one cycle.
        done_d     = gnt_q;
        done_sel_d = sel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            cmd_q      <= 4'b0000;
            sel_q      <= 2'd0;
            in_q       <= '0;
            done_q     <= '0;
            done_sel_q <= 2'd0;
        end else begin
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            cmd_q      <= cmd_d;
            sel_q      <= sel_d;
            in_q       <= in_d;
            done_q     <= done_d;
            done_sel_q <= done_sel_d;
        end
    end

    // Result is read combinationally in the done cycle: the bank has just
    // captured the update, so this is the post-update value.
    assign r_vec[0] = r0;
    assign r_vec[1] = r1;
    assign r_vec[2] = r2;
    assign r_vec[3] = r3;

    assign result  = (|done_q) ? r_vec[done_sel_q] : '0;

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign cb_rst  = cmd_q[3];
    assign cb_load = cmd_q[2];
    assign cb_up   = cmd_q[1];
    assign cb_down = cmd_q[0];
    assign cb_rs   = sel_q;
    assign cb_rd   = sel_q;
    assign cb_in   = in_q;

endmodule

// File: tb/tb_udl_count_sched.sv
module tb_udl_count_sched;

    localparam int N    = 4;
    localparam int NREQ = 4;
    localparam int MODV = 1 << N;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en    = 1'b0;
    logic [NREQ-1:0]      req   = '0;
    logic [2*NREQ-1:0]    op    = '0;
    logic [2*NREQ-1:0]    idx   = '0;
    logic [N*NREQ-1:0]    data  = '0;
    logic [NREQ-1:0]      gnt, done;
    logic [N-1:0]         result, cb_in;
    logic                 busy, cb_up, cb_down, cb_load, cb_rst;
    logic [1:0]           cb_rs, cb_rd;
    logic [N-1:0]         r3, r2, r1, r0;

    udl_count_sched #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .op(op), .idx(idx), .data(data),
        .gnt(gnt), .done(done), .result(result), .busy(busy),
        .cb_up(cb_up), .cb_down(cb_down), .cb_load(cb_load), .cb_rst(cb_rst),
        .cb_rs(cb_rs), .cb_rd(cb_rd), .cb_in(cb_in),
        .r3(r3), .r2(r2), .r1(r1), .r0(r0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Counter bank the scheduler drives (environment, not reference).
    logic [N-1:0] bank [4] = '{default: '0};
    always @(posedge clk) begin
        if (cb_rst)       bank[cb_rd] <= '0;
        else if (cb_load) bank[cb_rd] <= cb_in;
        else if (cb_up)   bank[cb_rd] <= bank[cb_rs] + 1'b1;
        else if (cb_down) bank[cb_rd] <= bank[cb_rs] - 1'b1;
    end
    assign r0 = bank[0];
    assign r1 = bank[1];
    assign r2 = bank[2];
    assign r3 = bank[3];

    // Reference: a queue of two stages (issued, completing) and its own counters.
    int m_ptr = 0;
    bit s1_v = 0;
    int s1_w = 0, s1_op = 0, s1_idx = 0, s1_data = 0;
    bit s2_v = 0;
    int s2_w = 0, s2_val = 0;
    int mcnt [4] = '{0, 0, 0, 0};
    bit a_v;
    int a_w, a_i;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0;
            s1_v  = 0;
            s2_v  = 0;
        end else begin
            a_v = 0;
            a_w = 0;
            for (int k = 0; k < NREQ; k++) begin
                a_i = (m_ptr + k) % NREQ;
                if (!a_v && req[a_i] && en && !(s1_v && s1_w == a_i)) begin
                    a_v = 1;
                    a_w = a_i;
                end
            end
            if (s1_v) begin
                case (s1_op)
                    0: mcnt[s1_idx] = (mcnt[s1_idx] + 1) % MODV;
                    1: mcnt[s1_idx] = (mcnt[s1_idx] + MODV - 1) % MODV;
                    2: mcnt[s1_idx] = s1_data;
                    default: mcnt[s1_idx] = 0;
                endcase
                s2_v   = 1;
                s2_w   = s1_w;
                s2_val = mcnt[s1_idx];
            end else begin
                s2_v = 0;
            end
            if (a_v) begin
                s1_v    = 1;
                s1_w    = a_w;
                s1_op   = int'(op[2*a_w +: 2]);
                s1_idx  = int'(idx[2*a_w +: 2]);
                s1_data = int'(data[N*a_w +: N]);
                m_ptr   = (a_w + 1) % NREQ;
            end else begin
                s1_v = 0;
            end
        end
    end

    logic [3:0] exp_cmd;
    always @(negedge clk) begin
        exp_cmd = 4'b0000;  // {rst, load, up, down}
        if (s1_v) begin
            case (s1_op)
                0: exp_cmd = 4'b0010;
                1: exp_cmd = 4'b0001;
                2: exp_cmd = 4'b0100;
                default: exp_cmd = 4'b1000;
            endcase
        end
        chk("m_gnt",  gnt,  s1_v ? (32'd1 << s1_w) : 32'd0);
        chk("m_busy", busy, s1_v);
        chk("m_cmd",  {cb_rst, cb_load, cb_up, cb_down}, exp_cmd);
        chk("m_rs",   cb_rs, s1_v ? s1_idx : 0);
        chk("m_rd",   cb_rd, s1_v ? s1_idx : 0);
        if (!s1_v || s1_op == 2) chk("m_cb_in", cb_in, s1_v ? s1_data : 0);
        chk("m_done", done, s2_v ? (32'd1 << s2_w) : 32'd0);
        if (s2_v) chk("m_result", result, s2_val);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input int o, input int t, input int d);
        req[i]           = 1'b1;
        op[2*i +: 2]     = o[1:0];
        idx[2*i +: 2]    = t[1:0];
        data[N*i +: N]   = d[N-1:0];
    endtask

    task automatic one_cmd(input int i, input int o, input int t, input int d,
                           input int exp_res, input string tag);
        set_req(i, o, t, d);
        step();
        chk({tag, "_gnt"}, gnt, 32'd1 << i);
        req[i] = 1'b0;
        step();
        chk({tag, "_done"}, done, 32'd1 << i);
        chk({tag, "_result"}, result, exp_res);
    endtask

    int w, prev;

    initial begin
        // Reset: everything quiet.
        repeat (3) step();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_cb", {cb_up, cb_down, cb_load, cb_rst, cb_rs, cb_rd, cb_in}, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        step();

        // LOAD idx 2 with A.
        set_req(0, 2, 2, 'hA);
        step();
        chk("ld_gnt", gnt, 4'b0001);
        chk("ld_cb_load", cb_load, 1);
        chk("ld_cb_rd", cb_rd, 2);
        chk("ld_cb_in", cb_in, 'hA);
        req[0] = 1'b0;
        step();
        chk("ld_done", done, 4'b0001);
        chk("ld_result", result, 'hA);
        chk("ld_r2", r2, 'hA);

        // Modulo wrap in both directions.
        one_cmd(0, 2, 1, 'hF, 'hF, "wrap_ld");
        one_cmd(0, 0, 1, 0, 'h0, "wrap_inc");
        one_cmd(0, 1, 1, 0, 'hF, "wrap_dec");

        // Round robin with all requesters held; reset first so ptr starts at 0.
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < NREQ; i++) set_req(i, 0, i, 0);
        prev = -1;
        for (int c = 0; c < 16; c++) begin
            step();
            w = -1;
            for (int i = 0; i < NREQ; i++) if (gnt[i]) w = i;
            chk("rr_order", w, c % NREQ);
            chk("rr_not_repeat", (w == prev), 0);
            prev = w;
        end
        req = '0;
        repeat (3) step();

        // Same counter back to back (ptr = 1 after the CLR, so requester 1 first).
        one_cmd(0, 3, 0, 0, 0, "clr0");
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        step();
        chk("bb_gnt1", gnt, 4'b0010);
        req[1] = 1'b0;
        step();
        chk("bb_gnt2", gnt, 4'b0001);
        chk("bb_done1", done, 4'b0010);
        chk("bb_result1", result, 1);
        req[0] = 1'b0;
        step();
        chk("bb_done2", done, 4'b0001);
        chk("bb_result2", result, 2);
        chk("bb_r0", r0, 2);

        // en dropped in a gnt cycle: counter 3 was 4 after round robin.
        set_req(2, 0, 3, 0);
        step();
        chk("en_gnt", gnt, 4'b0100);
        en     = 1'b0;
        req[2] = 1'b0;
        set_req(3, 0, 3, 0);
        set_req(0, 0, 0, 0);
        step();
        chk("en_done", done, 4'b0100);
        chk("en_result", result, 5);
        chk("en_off_gnt0", gnt, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("en_off_gnt", gnt, 0);
        end
        en = 1'b1;
        step();
        chk("reen_gnt_ptr", gnt, 4'b1000);
        req[3] = 1'b0;
        step();
        chk("reen_gnt2", gnt, 4'b0001);
        req[0] = 1'b0;
        repeat (2) step();

        // Reset in a gnt cycle: LOAD dropped, counter 1 keeps 3.
        set_req(1, 2, 1, 7);
        step();
        chk("mr_gnt", gnt, 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("mr_cb_load", cb_load, 0);
        chk("mr_gnt_clr", gnt, 0);
        chk("mr_busy", busy, 0);
        req[1] = 1'b0;
        step();
        chk("mr_done_a", done, 0);
        step();
        chk("mr_done_b", done, 0);
        chk("mr_r1", r1, 3);
        rst_n = 1'b1;
        step();
        chk("mr_done_c", done, 0);
        set_req(3, 0, 2, 0);
        set_req(0, 0, 2, 0);
        step();
        chk("mr_ptr0", gnt, 4'b0001);
        req[0] = 1'b0;
        step();
        chk("mr_gnt3", gnt, 4'b1000);
        req[3] = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
